reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register, PC and CPSR width.
REQ-002 The block SHALL have parameter NUM_REGS, default 16, meaning GPR count; ADDR_W = clog2(NUM_REGS).
REQ-003 The block SHALL have parameter NUM_RD, default 3, meaning number of GPR read ports.
REQ-004 The block SHALL have parameter PEND_W, default 2, meaning width of the per-register pending-write counter.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have ports if_pc_we (input, 1), if_pc_in (input, DATA_W) and if_pc_out (output, DATA_W), for PC write enable, PC next value and current PC.
REQ-008 The block SHALL have ports rd_num (input, NUM_RD*ADDR_W), rd_data (output, NUM_RD*DATA_W) and rd_busy (output, NUM_RD), for packed read addresses, read data and per-port pending-write flags.
REQ-009 The block SHALL have port exe_cpsr_out, output, DATA_W: current CPSR.
REQ-010 The block SHALL have ports iss_valid (input, 1), iss_rd_num (input, ADDR_W) and iss_ready (output, 1), for the issue request that marks a destination pending.
REQ-011 The block SHALL have ports wb_rd_write_en (input, 1), wb_rd_num (input, ADDR_W) and wb_rd_in (input, DATA_W), for the GPR writeback.
REQ-012 The block SHALL have ports wb_cpsr_write_en (input, 1) and wb_cpsr_in (input, DATA_W), for the CPSR writeback.

Function
REQ-013 GPR, PC and CPSR writes SHALL commit on the rising clk edge when their enable is high; reads SHALL be combinational from registered state.
REQ-014 if_pc_out SHALL equal the PC register; it SHALL hold when if_pc_we is low.
REQ-015 Each read port SHALL be independent; any number of ports MAY address the same register.
REQ-016 Each GPR SHALL have an unsigned pending counter pend[r] of PEND_W bits.
REQ-017 iss_ready SHALL be high iff pend[iss_rd_num] is below 2^PEND_W-1, or a writeback to the same register happens in the same cycle.
REQ-018 An issue handshake (iss_valid and iss_ready) SHALL increment pend[iss_rd_num] by 1.
REQ-019 A writeback (wb_rd_write_en) SHALL decrement pend[wb_rd_num] by 1; a writeback to a register with pend 0 SHALL write data and leave pend at 0 (no underflow).
REQ-020 A handshake issue and a writeback to the same register in the same cycle SHALL leave pend unchanged and SHALL write the data.
REQ-021 iss_valid with iss_ready low SHALL change no state; the requester SHALL hold the request.
REQ-022 rd_busy[p] SHALL be high iff pend[rd_num[p]] is nonzero, subject to REQ-026.
REQ-023 A writeback, CPSR write and PC write in the same cycle SHALL all commit independently.

Reset
REQ-024 When reset is low at a rising clk edge, all GPRs, PC, CPSR and every pend SHALL be cleared to 0; outputs SHALL then read rd_data=0, rd_busy=0, if_pc_out=0, exe_cpsr_out=0 and iss_ready=1.
REQ-025 Reset SHALL override simultaneous write, issue and writeback, including mid-sequence with pending counts.

Configuration
REQ-026 With macro REGFILE_BYPASS_EN defined:
- rd_data[p] SHALL return wb_rd_in when wb_rd_write_en is high and wb_rd_num equals rd_num[p].
- exe_cpsr_out SHALL return wb_cpsr_in when wb_cpsr_write_en is high.
- rd_busy[p] SHALL be low when that writeback brings pend to 0 in this cycle (pend 1 and no same-register issue).
Without the macro, reads SHALL reflect registered state only, giving one-cycle write-to-read latency.

Structure
REQ-027 A shared package pika_rf_pkg SHALL hold the default DATA_W, NUM_REGS, NUM_RD and PEND_W constants, plus the reset-value constant 0.
REQ-028 The pending counters and iss_ready logic SHALL live in one sub-module rf_scoreboard, parametrised by NUM_REGS, NUM_RD and PEND_W.

Verification
REQ-029 Write/read: write r3=0xDEADBEEF, then read r3 on all 3 ports. Without bypass, 0xDEADBEEF appears the cycle after the write; with bypass, in the same cycle.
REQ-030 Scoreboard saturation: issue r5 three times with PEND_W=2. Expect iss_ready low on the 4th request and rd_busy high; after 3 writebacks, rd_busy is low and iss_ready is high.
REQ-031 Simultaneous events: issue r7 and writeback r7 with pend=1 in the same cycle. Expect pend to stay 1, rd_busy high and data written.
REQ-032 Underflow: writeback r2=0x5 with pend 0. Expect r2=0x5, pend 0 and rd_busy low.
REQ-033 Reset mid-operation: load r1=0x11, PC=0x40, CPSR=0xF0000000 and pend[r4]=2, then drive reset low for one edge. Expect all outputs 0 and iss_ready=1.
REQ-034 Parallel writes: same-cycle PC=0x100, CPSR=0x1 and r15=0xA writes. Expect all three visible on the next cycle.

Source files
------------

// File: rtl/pika_rf_pkg.sv
// Shared defaults for the register file and its scoreboard.
// Reset value of every architectural register and pending counter.
package pika_rf_pkg;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_NUM_RD   = 3;
  localparam int DEF_PEND_W   = 2;
  localparam int RST_VAL      = 0;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-GPR pending-write counters and issue back-pressure.
// REGFILE_BYPASS_EN: busy drops in the cycle the last writeback lands.
module rf_scoreboard
  import pika_rf_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int PEND_W   = DEF_PEND_W,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_rd_num,
  output logic                     iss_ready,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_num,
  input  logic [NUM_RD*ADDR_W-1:0] rd_num,
  output logic [NUM_RD-1:0]        rd_busy
);

  localparam logic [PEND_W-1:0] MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] RST = PEND_W'(RST_VAL);

  logic [PEND_W-1:0] pend [NUM_REGS];
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] dec;
  logic                same;
  logic                hs;

  assign same = wb_en && (wb_num == iss_rd_num);
  assign iss_ready = (pend[iss_rd_num] != MAX) || same;
  assign hs = iss_valid && iss_ready;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc[r] = hs && (iss_rd_num == ADDR_W'(r));
      dec[r] = wb_en && (wb_num == ADDR_W'(r));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        pend[r] <= RST;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc[r] && dec[r])
          pend[r] <= pend[r];
        else if (inc[r])
          pend[r] <= pend[r] + 1'b1;
        else if (dec[r] && pend[r] != '0)
          pend[r] <= pend[r] - 1'b1;
      end
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [ADDR_W-1:0] a;
      a = rd_num[p*ADDR_W +: ADDR_W];
      rd_busy[p] = pend[a] != '0;
`ifdef REGFILE_BYPASS_EN
      if (wb_en && wb_num == a && pend[a] == PEND_W'(1)
          && !(hs && iss_rd_num == a))
        rd_busy[p] = 1'b0;
`endif
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// GPR file with PC, CPSR and a pending-write scoreboard.
// REGFILE_BYPASS_EN: writeback data forwarded to reads same cycle.
module reg_file_sb
  import pika_rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int PEND_W   = DEF_PEND_W,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     if_pc_we,
  input  logic [DATA_W-1:0]        if_pc_in,
  output logic [DATA_W-1:0]        if_pc_out,
  input  logic [NUM_RD*ADDR_W-1:0] rd_num,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [DATA_W-1:0]        exe_cpsr_out,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_rd_num,
  output logic                     iss_ready,
  input  logic                     wb_rd_write_en,
  input  logic [ADDR_W-1:0]        wb_rd_num,
  input  logic [DATA_W-1:0]        wb_rd_in,
  input  logic                     wb_cpsr_write_en,
  input  logic [DATA_W-1:0]        wb_cpsr_in
);

  localparam logic [DATA_W-1:0] RST = DATA_W'(RST_VAL);

  logic [DATA_W-1:0] gpr [NUM_REGS];
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] cpsr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        gpr[r] <= RST;
      pc   <= RST;
      cpsr <= RST;
    end else begin
      if (wb_rd_write_en)
        gpr[wb_rd_num] <= wb_rd_in;
      if (if_pc_we)
        pc <= if_pc_in;
      if (wb_cpsr_write_en)
        cpsr <= wb_cpsr_in;
    end
  end

  assign if_pc_out = pc;

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      logic [ADDR_W-1:0] a;
      a = rd_num[p*ADDR_W +: ADDR_W];
      rd_data[p*DATA_W +: DATA_W] = gpr[a];
`ifdef REGFILE_BYPASS_EN
      if (wb_rd_write_en && wb_rd_num == a)
        rd_data[p*DATA_W +: DATA_W] = wb_rd_in;
`endif
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign exe_cpsr_out = wb_cpsr_write_en ? wb_cpsr_in : cpsr;
`else
  assign exe_cpsr_out = cpsr;
`endif

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .PEND_W   (PEND_W)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .iss_valid  (iss_valid),
    .iss_rd_num (iss_rd_num),
    .iss_ready  (iss_ready),
    .wb_en      (wb_rd_write_en),
    .wb_num     (wb_rd_num),
    .rd_num     (rd_num),
    .rd_busy    (rd_busy)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb with default parameters.
// Handles both plain and REGFILE_BYPASS_EN builds.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_pc_we;
  logic [31:0] if_pc_in;
  logic [31:0] if_pc_out;
  logic [11:0] rd_num;
  logic [95:0] rd_data;
  logic [2:0]  rd_busy;
  logic [31:0] exe_cpsr_out;
  logic        iss_valid;
  logic [3:0]  iss_rd_num;
  logic        iss_ready;
  logic        wb_rd_write_en;
  logic [3:0]  wb_rd_num;
  logic [31:0] wb_rd_in;
  logic        wb_cpsr_write_en;
  logic [31:0] wb_cpsr_in;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk              (clk),
    .reset            (reset),
    .if_pc_we         (if_pc_we),
    .if_pc_in         (if_pc_in),
    .if_pc_out        (if_pc_out),
    .rd_num           (rd_num),
    .rd_data          (rd_data),
    .rd_busy          (rd_busy),
    .exe_cpsr_out     (exe_cpsr_out),
    .iss_valid        (iss_valid),
    .iss_rd_num       (iss_rd_num),
    .iss_ready        (iss_ready),
    .wb_rd_write_en   (wb_rd_write_en),
    .wb_rd_num        (wb_rd_num),
    .wb_rd_in         (wb_rd_in),
    .wb_cpsr_write_en (wb_cpsr_write_en),
    .wb_cpsr_in       (wb_cpsr_in)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_pc_we = 0; if_pc_in = '0;
    iss_valid = 0; iss_rd_num = '0;
    wb_rd_write_en = 0; wb_rd_num = '0; wb_rd_in = '0;
    wb_cpsr_write_en = 0; wb_cpsr_in = '0;
  endtask

  initial begin
    idle();
    rd_num = '0;
    reset = 0;
    tick();
    reset = 1;
    #1;
    chk("rst_rd_data", 128'(rd_data), 128'd0);
    chk("rst_busy", 128'(rd_busy), 128'd0);
    chk("rst_pc", 128'(if_pc_out), 128'd0);
    chk("rst_cpsr", 128'(exe_cpsr_out), 128'd0);
    chk("rst_ready", 128'(iss_ready), 128'd1);

    // write r3, read it on all ports
    rd_num = {4'd3, 4'd3, 4'd3};
    wb_rd_write_en = 1; wb_rd_num = 4'd3; wb_rd_in = 32'hDEADBEEF;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("wr_same_cycle", 128'(rd_data), 128'({3{32'hDEADBEEF}}));
`else
    chk("wr_same_cycle", 128'(rd_data), 128'd0);
`endif
    tick();
    idle();
    #1;
    chk("wr_next_cycle", 128'(rd_data), 128'({3{32'hDEADBEEF}}));
    chk("wr_busy", 128'(rd_busy), 128'd0);

    // writeback with pend 0: no underflow
    wb_rd_write_en = 1; wb_rd_num = 4'd2; wb_rd_in = 32'h5;
    tick();
    idle();
    rd_num = {4'd2, 4'd3, 4'd2};
    #1;
    chk("uf_data", 128'(rd_data),
        128'({32'h5, 32'hDEADBEEF, 32'h5}));
    chk("uf_busy", 128'(rd_busy), 128'd0);
    rd_num = {4'd2, 4'd2, 4'd2};
    iss_valid = 1; iss_rd_num = 4'd2;
    tick();
    idle();
    #1;
    chk("uf_pend_one", 128'(rd_busy), 128'b111);
    wb_rd_write_en = 1; wb_rd_num = 4'd2; wb_rd_in = 32'h6;
    tick();
    idle();
    #1;
    chk("uf_pend_zero", 128'(rd_busy), 128'd0);

    // saturate r5
    rd_num = {4'd5, 4'd5, 4'd5};
    iss_valid = 1; iss_rd_num = 4'd5;
    #1;
    chk("sat_ready0", 128'(iss_ready), 128'd1);
    tick(); tick(); tick();
    chk("sat_ready_low", 128'(iss_ready), 128'd0);
    chk("sat_busy", 128'(rd_busy), 128'b111);
    tick();
    chk("sat_hold", 128'(iss_ready), 128'd0);
    wb_rd_write_en = 1; wb_rd_num = 4'd5; wb_rd_in = 32'h55;
    #1;
    chk("sat_wb_ready", 128'(iss_ready), 128'd1);
    tick();
    wb_rd_write_en = 0;
    #1;
    chk("sat_still_full", 128'(iss_ready), 128'd0);
    iss_valid = 0;
    wb_rd_write_en = 1; wb_rd_num = 4'd5; wb_rd_in = 32'h56;
    tick(); tick();
    chk("sat_busy_2wb", 128'(rd_busy), 128'b111);
    tick();
    idle();
    iss_rd_num = 4'd5;
    #1;
    chk("sat_busy_done", 128'(rd_busy), 128'd0);
    chk("sat_ready_done", 128'(iss_ready), 128'd1);
    chk("sat_data", 128'(rd_data), 128'({3{32'h56}}));

    // simultaneous issue + writeback on r7 with pend 1
    rd_num = {4'd7, 4'd7, 4'd7};
    iss_valid = 1; iss_rd_num = 4'd7;
    tick();
    wb_rd_write_en = 1; wb_rd_num = 4'd7; wb_rd_in = 32'h77;
    tick();
    idle();
    #1;
    chk("sim_busy", 128'(rd_busy), 128'b111);
    chk("sim_data", 128'(rd_data), 128'({3{32'h77}}));
    wb_rd_write_en = 1; wb_rd_num = 4'd7; wb_rd_in = 32'h78;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("sim_last_wb", 128'(rd_busy), 128'd0);
`else
    chk("sim_last_wb", 128'(rd_busy), 128'b111);
`endif
    tick();
    idle();
    #1;
    chk("sim_pend_was1", 128'(rd_busy), 128'd0);

    // parallel PC / CPSR / r15 writes
    rd_num = {4'd15, 4'd15, 4'd15};
    if_pc_we = 1; if_pc_in = 32'h100;
    wb_cpsr_write_en = 1; wb_cpsr_in = 32'h1;
    wb_rd_write_en = 1; wb_rd_num = 4'd15; wb_rd_in = 32'hA;
    #1;
    chk("par_pc_pre", 128'(if_pc_out), 128'd0);
`ifdef REGFILE_BYPASS_EN
    chk("par_cpsr_pre", 128'(exe_cpsr_out), 128'd1);
`else
    chk("par_cpsr_pre", 128'(exe_cpsr_out), 128'd0);
`endif
    tick();
    idle();
    #1;
    chk("par_pc", 128'(if_pc_out), 128'h100);
    chk("par_cpsr", 128'(exe_cpsr_out), 128'h1);
    chk("par_r15", 128'(rd_data), 128'({3{32'hA}}));
    if_pc_in = 32'h200;
    tick();
    chk("pc_hold", 128'(if_pc_out), 128'h100);

    // reset mid-operation
    wb_rd_write_en = 1; wb_rd_num = 4'd1; wb_rd_in = 32'h11;
    if_pc_we = 1; if_pc_in = 32'h40;
    wb_cpsr_write_en = 1; wb_cpsr_in = 32'hF0000000;
    iss_valid = 1; iss_rd_num = 4'd4;
    tick();
    idle();
    iss_valid = 1; iss_rd_num = 4'd4;
    tick();
    idle();
    rd_num = {4'd4, 4'd1, 4'd4};
    #1;
    chk("mid_state", 128'({if_pc_out, exe_cpsr_out, rd_data[63:32]}),
        128'({32'h40, 32'hF0000000, 32'h11}));
    chk("mid_busy", 128'(rd_busy), 128'b101);
    reset = 0;
    wb_rd_write_en = 1; wb_rd_num = 4'd1; wb_rd_in = 32'h99;
    if_pc_we = 1; if_pc_in = 32'h80;
    wb_cpsr_write_en = 1; wb_cpsr_in = 32'h2;
    iss_valid = 1; iss_rd_num = 4'd4;
    tick();
    reset = 1;
    idle();
    iss_rd_num = 4'd4;
    #1;
    chk("mrst_rd_data", 128'(rd_data), 128'd0);
    chk("mrst_busy", 128'(rd_busy), 128'd0);
    chk("mrst_pc", 128'(if_pc_out), 128'd0);
    chk("mrst_cpsr", 128'(exe_cpsr_out), 128'd0);
    chk("mrst_ready", 128'(iss_ready), 128'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
